fft_iter_sequencer: RTL and testbench
=====================================

FFT_ITER_SEQUENCER -- requirements
Module: fft_iter_sequencer

Interface
REQ-001 The block SHALL have parameter N_LOG2, default 8, the log2 of the transform length N (N = 2^N_LOG2, range 2..12).
REQ-002 The block SHALL have parameter PIPE_LAT, default 4, the butterfly read-to-write latency in cycles (range 1..15).
REQ-003 The block SHALL have port CLK, input, 1 bit, the single clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit, the reset, which SHALL be asynchronous and active-low.
REQ-005 The block SHALL have port i_START, input, 1 bit, the request to begin one transform.
REQ-006 The block SHALL have port o_BUSY, output, 1 bit, high from the first RUN cycle through the last DRAIN cycle.
REQ-007 The block SHALL have port o_DONE, output, 1 bit, a one-cycle completion pulse.
REQ-008 The block SHALL have ports o_RD_EN (1 bit) and o_RD_ADDR_A, o_RD_ADDR_B (N_LOG2 bits each), outputs, the butterfly operand read pair.
REQ-009 The block SHALL have ports o_WR_EN (1 bit) and o_WR_ADDR_A, o_WR_ADDR_B (N_LOG2 bits each), outputs, the in-place result write pair.
REQ-010 The block SHALL have port o_TW_ADDR, output, N_LOG2-1 bits, the twiddle ROM index aligned with the read pair.
REQ-011 The block SHALL have port o_STAGE_OH, output, N_LOG2 bits, the one-hot current stage indicator.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-013 IDLE SHALL move to RUN on the edge where i_START=1; i_START SHALL be ignored in every other state.
REQ-014 RUN SHALL issue one butterfly per cycle, with k running 0..N/2-1 and o_RD_EN=1, for stage s running 0..N_LOG2-1.
REQ-015 Read addresses SHALL be A = ((k>>s)<<(s+1)) | (k & (2^s-1)) and B = A | 2^s.
REQ-016 o_TW_ADDR SHALL equal (k & (2^s-1)) << (N_LOG2-1-s).
REQ-017 After k=N/2-1, RUN SHALL move to DRAIN for exactly PIPE_LAT cycles with o_RD_EN=0, to avoid a read-after-write hazard across stages.
REQ-018 At the end of DRAIN, the FSM SHALL go to RUN with s+1 and k=0 if s<N_LOG2-1; otherwise it SHALL go to DONE.
REQ-019 DONE SHALL last one cycle with o_DONE=1 and o_BUSY=0, then SHALL return to IDLE; a new i_START SHALL be accepted only in IDLE.
REQ-020 o_WR_EN, o_WR_ADDR_A and o_WR_ADDR_B SHALL equal o_RD_EN, o_RD_ADDR_A and o_RD_ADDR_B delayed by exactly PIPE_LAT cycles, through a shift pipeline.
REQ-021 The last write of each stage SHALL occur in the final DRAIN cycle of that stage.
REQ-022 o_STAGE_OH SHALL rotate left by one position at each DRAIN-to-RUN transition.
REQ-023 o_STAGE_OH SHALL be restored to 1 at DONE, so it wraps ready for the next transform.
REQ-024 Total busy time SHALL be N_LOG2*(N/2+PIPE_LAT) cycles, and o_DONE SHALL follow the last busy cycle.
REQ-025 Address and twiddle outputs SHALL be registered and SHALL be held at their last value when the matching enable is 0.

Reset
REQ-026 While RST=0, the FSM SHALL be IDLE and k, s, all addresses, o_TW_ADDR, o_RD_EN, o_WR_EN, o_BUSY and o_DONE SHALL be 0.
REQ-027 While RST=0, o_STAGE_OH SHALL be 1 and the write-delay pipeline SHALL be cleared.
REQ-028 Reset asserted mid-transform SHALL abort immediately, with no pending writes emitted after release.

Structure
REQ-029 A shared header SHALL hold the FSM state encodings and a clog2 function for the PIPE_LAT counter width.
REQ-030 o_STAGE_OH SHALL be produced by an instance of the team's ring_shift_register configured as left-shift, rising-edge, asynchronous active-low reset, reset value 1, and width N_LOG2.
REQ-031 The instance enable SHALL be the stage-advance strobe, and its reset SHALL be RST OR'd with the DONE strobe.

Verification
REQ-032 Stage 0 with N_LOG2=3 and PIPE_LAT=2 SHALL give read pairs (0,1),(2,3),(4,5),(6,7) with o_TW_ADDR=0,0,0,0.
REQ-033 Stage 1 with N_LOG2=3 and PIPE_LAT=2 SHALL give read pairs (0,2),(1,3),(4,6),(5,7) with o_TW_ADDR=0,2,0,2.
REQ-034 Stage 2 with N_LOG2=3 and PIPE_LAT=2 SHALL give read pairs (0,4),(1,5),(2,6),(3,7) with o_TW_ADDR=0,1,2,3; o_BUSY SHALL be high for 18 cycles and o_DONE SHALL pulse on cycle 19.
REQ-035 Write check: every write pair SHALL equal the read pair from 2 cycles earlier, with no reads during the 2 DRAIN cycles.
REQ-036 i_START held high for the whole transform SHALL cause no restart; after DONE and IDLE, a second transform SHALL begin with o_STAGE_OH=3'b001.
REQ-037 RST pulled low at stage 1 k=2 SHALL force all outputs to reset values at once; after release, no o_WR_EN pulse SHALL occur until a new i_START.
REQ-038 With N_LOG2=2 and PIPE_LAT=1, o_STAGE_OH SHALL step 01 then 10 then 01, and o_DONE SHALL pulse after 6 busy cycles.

Source files
------------

// File: rtl/fft_iter_sequencer_pkg.sv
// Shared definitions for the iterative radix-2 FFT address sequencer:
// FSM state encoding and a constant-evaluable ceil(log2) helper.
package fft_iter_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // ceil(log2(value)); used to size the drain and stage counters
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/ring_shift_register.sv
// Generic rotating shift register with enable and asynchronous active-low
// reset to a configurable value.
module ring_shift_register #(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] RST_VAL    = WIDTH'(1),
  parameter bit               SHIFT_LEFT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  // Rotate by one position on each enabled rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= SHIFT_LEFT ? {q[WIDTH-2:0], q[WIDTH-1]} : {q[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/fft_iter_sequencer.sv
// Iterative in-place radix-2 FFT sequencer: walks every stage issuing one
// butterfly read pair per cycle, drains the butterfly pipeline between
// stages, and replays the read pairs as write pairs PIPE_LAT cycles later.
module fft_iter_sequencer
  import fft_iter_sequencer_pkg::*;
#(
  parameter int N_LOG2   = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_START,
  output logic              o_BUSY,
  output logic              o_DONE,
  output logic              o_RD_EN,
  output logic [N_LOG2-1:0] o_RD_ADDR_A,
  output logic [N_LOG2-1:0] o_RD_ADDR_B,
  output logic              o_WR_EN,
  output logic [N_LOG2-1:0] o_WR_ADDR_A,
  output logic [N_LOG2-1:0] o_WR_ADDR_B,
  output logic [N_LOG2-2:0] o_TW_ADDR,
  output logic [N_LOG2-1:0] o_STAGE_OH
);

  localparam int K_W = N_LOG2 - 1;
  localparam int S_W = clog2(N_LOG2);
  localparam int D_W = clog2(PIPE_LAT + 1);

  localparam logic [K_W-1:0] K_LAST = K_W'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(N_LOG2 - 1);

  state_t             state;
  logic [S_W-1:0]     s;
  logic [K_W-1:0]     k;
  logic [D_W-1:0]     drain_cnt;

  logic [S_W-1:0]     iss_s;
  logic [K_W-1:0]     iss_k;
  logic [N_LOG2-1:0]  kx;
  logic [N_LOG2-1:0]  mask;
  logic [N_LOG2-1:0]  iss_a;
  logic [N_LOG2-1:0]  iss_b;
  logic [K_W-1:0]     iss_tw;

  logic               stage_adv;
  logic               ring_rst_n;

  logic [PIPE_LAT-1:0]             pipe_en;
  logic [PIPE_LAT-1:0][N_LOG2-1:0] pipe_a;
  logic [PIPE_LAT-1:0][N_LOG2-1:0] pipe_b;

  // Butterfly (stage, index) to be issued on the next edge and its addresses
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    iss_s = '0;
    iss_k = '0;
    case (state)
      ST_RUN: begin
        iss_s = s;
        iss_k = k + 1'b1;
      end
      ST_DRAIN: begin
        iss_s = s + 1'b1;
        iss_k = '0;
      end
      default: ;
    endcase
    kx     = {1'b0, iss_k};
    mask   = (N_LOG2'(1) << iss_s) - N_LOG2'(1);
    iss_a  = ((kx >> iss_s) << iss_s << 1) | (kx & mask);
    iss_b  = iss_a | (N_LOG2'(1) << iss_s);
    iss_tw = K_W'((kx & mask) << (K_W - int'(iss_s)));
  end

  // Sequencer FSM with registered read, busy and done outputs
  // NOTE: state and outputs use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= ST_IDLE;
      s           <= '0;
      k           <= '0;
      drain_cnt   <= '0;
      o_BUSY      <= 1'b0;
      o_DONE      <= 1'b0;
      o_RD_EN     <= 1'b0;
      o_RD_ADDR_A <= '0;
      o_RD_ADDR_B <= '0;
      o_TW_ADDR   <= '0;
    end else begin
      o_DONE  <= 1'b0;
      o_RD_EN <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_START) begin
            state       <= ST_RUN;
            s           <= '0;
            k           <= '0;
            o_BUSY      <= 1'b1;
            o_RD_EN     <= 1'b1;
            o_RD_ADDR_A <= iss_a;
            o_RD_ADDR_B <= iss_b;
            o_TW_ADDR   <= iss_tw;
          end
        end
        ST_RUN: begin
          if (k == K_LAST) begin
            state     <= ST_DRAIN;
            drain_cnt <= D_W'(PIPE_LAT - 1);
          end else begin
            k           <= iss_k;
            o_RD_EN     <= 1'b1;
            o_RD_ADDR_A <= iss_a;
            o_RD_ADDR_B <= iss_b;
            o_TW_ADDR   <= iss_tw;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt != '0) begin
            drain_cnt <= drain_cnt - 1'b1;
          end else if (s == S_LAST) begin
            state  <= ST_DONE;
            o_BUSY <= 1'b0;
            o_DONE <= 1'b1;
          end else begin
            state       <= ST_RUN;
            s           <= iss_s;
            k           <= '0;
            o_RD_EN     <= 1'b1;
            o_RD_ADDR_A <= iss_a;
            o_RD_ADDR_B <= iss_b;
            o_TW_ADDR   <= iss_tw;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          s     <= '0;
          k     <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Last drain cycle of a non-final stage moves the one-hot stage marker
  assign stage_adv  = (state == ST_DRAIN) && (drain_cnt == '0) && (s != S_LAST);
  // The DONE pulse re-arms the stage marker for the next transform
  assign ring_rst_n = RST & ~o_DONE;

  ring_shift_register #(
    .WIDTH      (N_LOG2),
    .RST_VAL    (N_LOG2'(1)),
    .SHIFT_LEFT (1'b1)
  ) u_stage_ring (
    .clk   (CLK),
    .rst_n (ring_rst_n),
    .en    (stage_adv),
    .q     (o_STAGE_OH)
  );

  // Write-pair delay line; addresses only advance with a valid entry so the
  // write outputs hold their last value while idle
  // NOTE: the delay line is fully reset so an aborted transform leaves no
  // pending write behind.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pipe_en <= '0;
      pipe_a  <= '0;
      pipe_b  <= '0;
    end else begin
      pipe_en[0] <= o_RD_EN;
      if (o_RD_EN) begin
        pipe_a[0] <= o_RD_ADDR_A;
        pipe_b[0] <= o_RD_ADDR_B;
      end
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_en[i] <= pipe_en[i-1];
        if (pipe_en[i-1]) begin
          pipe_a[i] <= pipe_a[i-1];
          pipe_b[i] <= pipe_b[i-1];
        end
      end
    end
  end

  assign o_WR_EN     = pipe_en[PIPE_LAT-1];
  assign o_WR_ADDR_A = pipe_a[PIPE_LAT-1];
  assign o_WR_ADDR_B = pipe_b[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_iter_sequencer.sv
// Self-checking bench for fft_iter_sequencer. Two instances: N_LOG2=3 /
// PIPE_LAT=2 (sel 0) and N_LOG2=2 / PIPE_LAT=1 (sel 1). Expected outputs come
// from a cycle-indexed arithmetic model of the transform schedule.
module tb_fft_iter_sequencer;

  typedef struct packed {
    logic        en;
    logic [11:0] a;
    logic [11:0] b;
    logic [10:0] tw;
  } rd_t;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [11:0] oh;
    rd_t         rd;
    logic        wr_en;
    logic [11:0] wr_a;
    logic [11:0] wr_b;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start3 = 1'b0;
  logic start2 = 1'b0;

  logic       busy3, done3, rd_en3, wr_en3;
  logic [2:0] rd_a3, rd_b3, wr_a3, wr_b3, oh3;
  logic [1:0] tw3;
  logic       busy2, done2, rd_en2, wr_en2;
  logic [1:0] rd_a2, rd_b2, wr_a2, wr_b2, oh2;
  logic [0:0] tw2;

  int n_cmp = 0;
  int n_bad = 0;
  bit had_prev [2];

  // Hand-derived N=8 read schedule, indexed [stage][k]
  int ta [3][4] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
  int tb [3][4] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
  int tt [3][4] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};

  always #5 clk = ~clk;

  fft_iter_sequencer #(.N_LOG2(3), .PIPE_LAT(2)) dut3 (
    .CLK(clk), .RST(rst_n), .i_START(start3),
    .o_BUSY(busy3), .o_DONE(done3),
    .o_RD_EN(rd_en3), .o_RD_ADDR_A(rd_a3), .o_RD_ADDR_B(rd_b3),
    .o_WR_EN(wr_en3), .o_WR_ADDR_A(wr_a3), .o_WR_ADDR_B(wr_b3),
    .o_TW_ADDR(tw3), .o_STAGE_OH(oh3)
  );

  fft_iter_sequencer #(.N_LOG2(2), .PIPE_LAT(1)) dut2 (
    .CLK(clk), .RST(rst_n), .i_START(start2),
    .o_BUSY(busy2), .o_DONE(done2),
    .o_RD_EN(rd_en2), .o_RD_ADDR_A(rd_a2), .o_RD_ADDR_B(rd_b2),
    .o_WR_EN(wr_en2), .o_WR_ADDR_A(wr_a2), .o_WR_ADDR_B(wr_b2),
    .o_TW_ADDR(tw2), .o_STAGE_OH(oh2)
  );

  // Read pair most recently issued at schedule cycle x (x = 0 is the first
  // busy cycle); before the transform the pair left by a previous one holds.
  function automatic rd_t read_at(int lg, int pl, int x, bit prev);
    int half, per, total, st, k;
    rd_t r;
    half  = 1 << (lg - 1);
    per   = half + pl;
    total = lg * per;
    r     = '0;
    if (x < 0 && !prev) return r;
    st = lg - 1;
    k  = half - 1;
    if (x >= 0 && x < total) begin
      st = x / per;
      if (x % per < half) begin
        k    = x % per;
        r.en = 1'b1;
      end
    end
    r.a  = 12'(((k >> st) << (st + 1)) | (k & ((1 << st) - 1)));
    r.b  = r.a | 12'(1 << st);
    r.tw = 11'((k & ((1 << st) - 1)) << (lg - 1 - st));
    return r;
  endfunction

  function automatic obs_t model(int sel, int c, bit prev);
    int lg, pl, per, total;
    obs_t e;
    rd_t  w;
    lg    = (sel != 0) ? 2 : 3;
    pl    = (sel != 0) ? 1 : 2;
    per   = (1 << (lg - 1)) + pl;
    total = lg * per;
    e      = '0;
    e.busy = (c >= 0 && c < total);
    e.done = (c == total);
    e.oh   = e.busy ? 12'(1 << (c / per)) : 12'd1;
    e.rd   = read_at(lg, pl, c, prev);
    w      = read_at(lg, pl, c - pl, prev);
    e.wr_en = w.en;
    e.wr_a  = w.a;
    e.wr_b  = w.b;
    return e;
  endfunction

  function automatic int total_of(int sel);
    return (sel != 0) ? 2 * (2 + 1) : 3 * (4 + 2);
  endfunction

  function automatic obs_t sample(int sel);
    obs_t o;
    o = '0;
    if (sel == 0) begin
      o.busy = busy3; o.done = done3; o.oh = 12'(oh3);
      o.rd.en = rd_en3; o.rd.a = 12'(rd_a3); o.rd.b = 12'(rd_b3); o.rd.tw = 11'(tw3);
      o.wr_en = wr_en3; o.wr_a = 12'(wr_a3); o.wr_b = 12'(wr_b3);
    end else begin
      o.busy = busy2; o.done = done2; o.oh = 12'(oh2);
      o.rd.en = rd_en2; o.rd.a = 12'(rd_a2); o.rd.b = 12'(rd_b2); o.rd.tw = 11'(tw2);
      o.wr_en = wr_en2; o.wr_a = 12'(wr_a2); o.wr_b = 12'(wr_b2);
    end
    return o;
  endfunction

  function automatic string fmt(obs_t v);
    return $sformatf("busy=%b done=%b oh=%0h rd=%b/%0d/%0d tw=%0d wr=%b/%0d/%0d",
                     v.busy, v.done, v.oh, v.rd.en, v.rd.a, v.rd.b, v.rd.tw,
                     v.wr_en, v.wr_a, v.wr_b);
  endfunction

  task automatic set_start(int sel, logic v);
    if (sel == 0) start3 = v;
    else          start2 = v;
  endtask

  // Reset values on both instances, during and just after reset
  task automatic test_reset();
    obs_t o, e;
    rst_n = 1'b0; start3 = 1'b0; start2 = 1'b0;
    repeat (3) @(negedge clk);
    e = '0; e.oh = 12'd1;
    for (int sel = 0; sel < 2; sel++) begin
      o = sample(sel); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL reset_state sel=%0d got %s exp %s", sel, fmt(o), fmt(e)); end
    end
    rst_n = 1'b1; had_prev[0] = 1'b0; had_prev[1] = 1'b0;
    repeat (2) @(negedge clk);
    for (int sel = 0; sel < 2; sel++) begin
      o = sample(sel); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL idle_after_reset sel=%0d got %s exp %s", sel, fmt(o), fmt(e)); end
    end
  endtask

  // One N=8 transform with start noise, plus the fixed read-pair tables
  task automatic test_n8_transform();
    obs_t o, e;
    int busy_n = 0, done_n = 0, done_at = -1, st, kk;
    int ca [3][4], cb [3][4], ct [3][4];
    for (int i = 0; i < 3; i++) for (int j = 0; j < 4; j++) begin ca[i][j] = -1; cb[i][j] = -1; ct[i][j] = -1; end
    repeat ($urandom_range(1, 4)) @(negedge clk);
    start3 = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      o = sample(0); e = model(0, c, had_prev[0]); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL n8_cycle c=%0d got %s exp %s", c, fmt(o), fmt(e)); end
      if (o.busy) busy_n++;
      if (o.done) begin done_n++; if (done_at < 0) done_at = c + 1; end
      if (c < 18 && o.rd.en) begin
        st = c / 6; kk = c % 6;
        if (kk < 4) begin ca[st][kk] = int'(o.rd.a); cb[st][kk] = int'(o.rd.b); ct[st][kk] = int'(o.rd.tw); end
      end
      start3 = (c <= 18) ? 1'($urandom) : 1'b0;
    end
    for (int i = 0; i < 3; i++) for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (ca[i][j] !== ta[i][j] || cb[i][j] !== tb[i][j] || ct[i][j] !== tt[i][j]) begin
        n_bad++;
        $display("FAIL n8_table s=%0d k=%0d got (%0d,%0d) tw=%0d exp (%0d,%0d) tw=%0d",
                 i, j, ca[i][j], cb[i][j], ct[i][j], ta[i][j], tb[i][j], tt[i][j]);
      end
    end
    n_cmp++;
    if (busy_n !== 18) begin n_bad++; $display("FAIL n8_busy_cycles got %0d exp 18", busy_n); end
    n_cmp++;
    if (done_at !== 19 || done_n !== 1) begin n_bad++; $display("FAIL n8_done_cycle got cycle %0d count %0d exp cycle 19 count 1", done_at, done_n); end
    had_prev[0] = 1'b1;
  endtask

  // i_START held high: no restart mid-transform, clean second transform
  task automatic test_back_to_back();
    obs_t o, e;
    repeat (2) @(negedge clk);
    start3 = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      o = sample(0);
      e = (c <= 19) ? model(0, c, had_prev[0]) : model(0, c - 20, 1'b1);
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL b2b_cycle c=%0d got %s exp %s", c, fmt(o), fmt(e)); end
      if (c == 20) begin
        n_cmp++;
        if (oh3 !== 3'b001 || busy3 !== 1'b1) begin n_bad++; $display("FAIL b2b_second_start got oh=%b busy=%b exp oh=001 busy=1", oh3, busy3); end
      end
      start3 = (c < 38) ? 1'b1 : 1'b0;
    end
    had_prev[0] = 1'b1;
  endtask

  // N=4, PIPE_LAT=1: stage marker 01,10,01 and six busy cycles
  task automatic test_n4_transform();
    obs_t o, e;
    int busy_n = 0;
    logic [1:0] exp_oh [3] = '{2'b01, 2'b10, 2'b01};
    @(negedge clk);
    start2 = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      o = sample(1); e = model(1, c, had_prev[1]); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL n4_cycle c=%0d got %s exp %s", c, fmt(o), fmt(e)); end
      if (o.busy) busy_n++;
      if (c % 3 == 0 && c <= 6) begin
        n_cmp++;
        if (oh2 !== exp_oh[c/3]) begin n_bad++; $display("FAIL n4_stage_oh c=%0d got %b exp %b", c, oh2, exp_oh[c/3]); end
      end
      if (c == 6) begin
        n_cmp++;
        if (done2 !== 1'b1 || busy_n !== 6) begin n_bad++; $display("FAIL n4_done got done=%b busy_cycles=%0d exp done=1 busy_cycles=6", done2, busy_n); end
      end
      start2 = 1'b0;
    end
    had_prev[1] = 1'b1;
  endtask

  // Reset at stage 1, k=2: immediate abort, no trailing writes
  task automatic test_abort();
    obs_t o, e;
    @(negedge clk);
    start3 = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      o = sample(0); e = model(0, c, had_prev[0]); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL abort_run c=%0d got %s exp %s", c, fmt(o), fmt(e)); end
      start3 = 1'b0;
    end
    n_cmp++;
    if (rd_a3 !== 3'd4 || rd_b3 !== 3'd6 || tw3 !== 2'd0) begin n_bad++; $display("FAIL abort_point got (%0d,%0d) tw=%0d exp (4,6) tw=0", rd_a3, rd_b3, tw3); end
    rst_n = 1'b0;
    #1;
    e = '0; e.oh = 12'd1;
    o = sample(0); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL abort_async got %s exp %s", fmt(o), fmt(e)); end
    @(negedge clk);
    rst_n = 1'b1; had_prev[0] = 1'b0; had_prev[1] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int sel = 0; sel < 2; sel++) begin
        o = sample(sel); e = model(sel, -1, 1'b0); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL abort_quiet sel=%0d c=%0d got %s exp %s", sel, c, fmt(o), fmt(e)); end
      end
    end
  endtask

  // Random instance, idle gap and start noise for several transforms
  task automatic test_random_transforms();
    obs_t o, e;
    int sel, total;
    for (int it = 0; it < 6; it++) begin
      sel   = int'($urandom_range(0, 1));
      total = total_of(sel);
      repeat ($urandom_range(1, 5)) @(negedge clk);
      set_start(sel, 1'b1);
      for (int c = 0; c <= total + 2; c++) begin
        @(negedge clk);
        o = sample(sel); e = model(sel, c, had_prev[sel]); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL rand_cycle it=%0d sel=%0d c=%0d got %s exp %s", it, sel, c, fmt(o), fmt(e)); end
        set_start(sel, (c <= total) ? 1'($urandom) : 1'b0);
      end
      had_prev[sel] = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_n8_transform();
    test_back_to_back();
    test_n4_transform();
    test_abort();
    test_random_transforms();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
